pc_sequencer: RTL and testbench

Owns the program counter and sequences instruction fetch around control-flow changes. Consumes the branch-taken decision from the branch unit, plus JAL/JALR, trap and MRET events from EX/CSR. Selects next PC, enforces target alignment, and drives a multi-cycle flush of IF/ID after every redirect. Sits between the EX stage and the instruction-memory address port.

---
 rtl/pc_sequencer_pkg.sv | 19 +
 rtl/pc_sequencer_next_pc_mux.sv | 67 ++++++
 rtl/pc_sequencer.sv | 140 ++++++++++++++
 tb/tb_pc_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: opcode
// constants, FSM state encoding and the default reset PC.
package pc_sequencer_pkg;

    // EX-stage opcode[6:2] values that can change control flow
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;

    // PC loaded while reset is asserted unless the top overrides it
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } seq_state_e;

endpackage

// File: rtl/pc_sequencer_next_pc_mux.sv
// Next-PC selection: computes control-flow targets, checks their
// alignment and applies the trap > mret > EX redirect > stall > +4
// priority. Purely combinational; the caller decides which state
// actually consumes the result.
module pc_sequencer_next_pc_mux
    import pc_sequencer_pkg::*;
(
    input  logic        cf_enable_in,     // EX redirects honoured (RUN only)
    input  logic [31:0] pc_in,
    input  logic        stall_in,
    input  logic        ex_valid_in,
    input  logic [4:0]  opcode_6_to_2_in,
    input  logic [31:0] ex_pc_in,
    input  logic [31:0] imm_in,
    input  logic [31:0] rs1_in,
    input  logic        branch_taken_in,
    input  logic        trap_taken_in,
    input  logic [31:0] trap_vector_in,
    input  logic        mret_in,
    input  logic [31:0] epc_in,
    output logic [31:0] next_pc_out,
    output logic        redirect_out,     // PC jumped; start a flush
    output logic        misaligned_out,
    output logic [31:0] bad_target_out
);

    logic [31:0] pc_rel_target;
    logic [31:0] jalr_target;
    logic [31:0] cf_target;
    logic        cf_taken;
    logic [31:0] seq_pc;

    // Target arithmetic, alignment check and priority select
    always_comb begin
        pc_rel_target = ex_pc_in + imm_in;
        // JALR clears bit 0 before use; bit 1 still makes it misaligned
        jalr_target   = (rs1_in + imm_in) & ~32'h1;
        cf_target     = (opcode_6_to_2_in == OP_JALR) ? jalr_target : pc_rel_target;
        cf_taken      = ex_valid_in &&
                        (((opcode_6_to_2_in == OP_BRANCH) && branch_taken_in) ||
                         (opcode_6_to_2_in == OP_JAL) ||
                         (opcode_6_to_2_in == OP_JALR));
        seq_pc        = stall_in ? pc_in : (pc_in + 32'd4);

        next_pc_out    = seq_pc;
        redirect_out   = 1'b0;
        misaligned_out = 1'b0;
        bad_target_out = cf_target;

        if (trap_taken_in) begin
            next_pc_out  = trap_vector_in & ~32'h3;
            redirect_out = 1'b1;
        end else if (mret_in) begin
            next_pc_out  = epc_in & ~32'h3;
            redirect_out = 1'b1;
        end else if (cf_enable_in && cf_taken) begin
            if (cf_target[1:0] != 2'b00) begin
                // Report only; sequencing continues until the CSR unit traps
                misaligned_out = 1'b1;
            end else begin
                next_pc_out  = cf_target;
                redirect_out = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter owner: boots from RESET_PC, steps by 4, redirects on
// traps / mret / taken control flow, and holds flush_out high for
// FLUSH_CYCLES cycles after every redirect so IF/ID drop stale work.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        stall_in,
    input  logic        ex_valid_in,
    input  logic [4:0]  opcode_6_to_2_in,
    input  logic [31:0] ex_pc_in,
    input  logic [31:0] imm_in,
    input  logic [31:0] rs1_in,
    input  logic        branch_taken_in,
    input  logic        trap_taken_in,
    input  logic [31:0] trap_vector_in,
    input  logic        mret_in,
    input  logic [31:0] epc_in,
    output logic [31:0] pc_out,
    output logic        pc_valid_out,
    output logic        flush_out,
    output logic        misaligned_out,
    output logic [31:0] bad_target_out
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    seq_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic        pc_valid_q, pc_valid_d;
    logic        flush_q, flush_d;
    logic        misaligned_q, misaligned_d;
    logic [31:0] bad_target_q, bad_target_d;

    logic [31:0] mux_next_pc;
    logic        mux_redirect;
    logic        mux_misaligned;
    logic [31:0] mux_bad_target;

    pc_sequencer_next_pc_mux u_next_pc_mux (
        .cf_enable_in     (state_q == ST_RUN),
        .pc_in            (pc_q),
        .stall_in         (stall_in),
        .ex_valid_in      (ex_valid_in),
        .opcode_6_to_2_in (opcode_6_to_2_in),
        .ex_pc_in         (ex_pc_in),
        .imm_in           (imm_in),
        .rs1_in           (rs1_in),
        .branch_taken_in  (branch_taken_in),
        .trap_taken_in    (trap_taken_in),
        .trap_vector_in   (trap_vector_in),
        .mret_in          (mret_in),
        .epc_in           (epc_in),
        .next_pc_out      (mux_next_pc),
        .redirect_out     (mux_redirect),
        .misaligned_out   (mux_misaligned),
        .bad_target_out   (mux_bad_target)
    );

    // Next-state, next-PC and registered-output computation
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        flush_cnt_d  = flush_cnt_q;
        flush_d      = 1'b0;
        misaligned_d = 1'b0;
        bad_target_d = bad_target_q;

        case (state_q)
            ST_BOOT: begin
                // PC already holds RESET_PC; it becomes the first fetch
                state_d = ST_RUN;
            end
            ST_RUN: begin
                pc_d = mux_next_pc;
                if (mux_redirect) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FLUSH_LOAD;
                    flush_d     = 1'b1;
                end else if (mux_misaligned) begin
                    misaligned_d = 1'b1;
                    bad_target_d = mux_bad_target;
                end
            end
            ST_FLUSH: begin
                // Fetch keeps going; only trap/mret can re-redirect here
                pc_d = mux_next_pc;
                if (mux_redirect) begin
                    flush_cnt_d = FLUSH_LOAD;
                    flush_d     = 1'b1;
                end else if (flush_cnt_q <= 3'd1) begin
                    flush_cnt_d = 3'd0;
                    state_d     = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                    flush_d     = 1'b1;
                end
            end
            default: begin
                state_d     = ST_BOOT;
                flush_cnt_d = 3'd0;
            end
        endcase

        pc_valid_d = (state_d != ST_BOOT);
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_PC;
            flush_cnt_q  <= 3'd0;
            pc_valid_q   <= 1'b0;
            flush_q      <= 1'b0;
            misaligned_q <= 1'b0;
            bad_target_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            flush_cnt_q  <= flush_cnt_d;
            pc_valid_q   <= pc_valid_d;
            flush_q      <= flush_d;
            misaligned_q <= misaligned_d;
            bad_target_q <= bad_target_d;
        end
    end

    assign pc_out         = pc_q;
    assign pc_valid_out   = pc_valid_q;
    assign flush_out      = flush_q;
    assign misaligned_out = misaligned_q;
    assign bad_target_out = bad_target_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_pc_sequencer;

    localparam logic [4:0]  T_BRANCH = 5'b11000;
    localparam logic [4:0]  T_JAL    = 5'b11011;
    localparam logic [4:0]  T_JALR   = 5'b11001;
    localparam logic [4:0]  T_ALU    = 5'b01100;
    localparam logic [31:0] T_RESET_PC = 32'h0000_0000;
    localparam int          T_FLUSH    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        ex_valid;
    logic [4:0]  opcode;
    logic [31:0] ex_pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        br_taken;
    logic        trap;
    logic [31:0] trap_vec;
    logic        mret;
    logic [31:0] epc;
    logic [31:0] pc_o;
    logic        pc_valid_o;
    logic        flush_o;
    logic        misal_o;
    logic [31:0] bad_o;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    bit          m_booted;
    logic [31:0] m_pc;
    int          m_flush_left;
    bit          m_misal;
    logic [31:0] m_bad;

    pc_sequencer #(
        .RESET_PC     (T_RESET_PC),
        .FLUSH_CYCLES (T_FLUSH)
    ) dut (
        .clk_in           (clk),
        .rst_in           (rst),
        .stall_in         (stall),
        .ex_valid_in      (ex_valid),
        .opcode_6_to_2_in (opcode),
        .ex_pc_in         (ex_pc),
        .imm_in           (imm),
        .rs1_in           (rs1),
        .branch_taken_in  (br_taken),
        .trap_taken_in    (trap),
        .trap_vector_in   (trap_vec),
        .mret_in          (mret),
        .epc_in           (epc),
        .pc_out           (pc_o),
        .pc_valid_out     (pc_valid_o),
        .flush_out        (flush_o),
        .misaligned_out   (misal_o),
        .bad_target_out   (bad_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        stall = 0; ex_valid = 0; opcode = T_ALU; ex_pc = 0; imm = 0; rs1 = 0;
        br_taken = 0; trap = 0; trap_vec = 0; mret = 0; epc = 0;
    endtask

    task automatic model_reset();
        m_booted = 0; m_pc = T_RESET_PC; m_flush_left = 0; m_misal = 0; m_bad = 0;
    endtask

    // Model of one clock edge given the inputs currently applied
    task automatic model_step();
        logic [31:0] tgt;
        bit          cf;
        bit          in_flush;
        m_misal = 0;
        if (!m_booted) begin
            m_booted = 1;
            return;
        end
        in_flush = (m_flush_left > 0);
        tgt = (opcode == T_JALR) ? ((rs1 + imm) & ~32'h1) : (ex_pc + imm);
        cf  = ex_valid && ((opcode == T_BRANCH && br_taken) || opcode == T_JAL || opcode == T_JALR);
        if (trap) begin
            m_pc = trap_vec & ~32'h3;
            m_flush_left = T_FLUSH;
        end else if (mret) begin
            m_pc = epc & ~32'h3;
            m_flush_left = T_FLUSH;
        end else if (!in_flush && cf && (tgt % 4 == 0)) begin
            m_pc = tgt;
            m_flush_left = T_FLUSH;
        end else begin
            if (!in_flush && cf) begin
                m_misal = 1;
                m_bad   = tgt;
            end
            if (!stall) m_pc = m_pc + 32'd4;
            if (in_flush) m_flush_left--;
        end
    endtask

    // Advance one clock, update the model and compare all outputs
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("pc_out", pc_o, m_pc);
        chk("pc_valid_out", {31'b0, pc_valid_o}, {31'b0, m_booted});
        chk("flush_out", {31'b0, flush_o}, {31'b0, (m_flush_left > 0)});
        chk("misaligned_out", {31'b0, misal_o}, {31'b0, m_misal});
        if (m_misal) chk("bad_target_out", bad_o, m_bad);
        $display("cycle t=%0t pc=0x%08h valid=%0b flush=%0b misal=%0b bad=0x%08h",
                 $time, pc_o, pc_valid_o, flush_o, misal_o, bad_o);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_pc"}, pc_o, T_RESET_PC);
        chk({tag, "_valid"}, {31'b0, pc_valid_o}, 32'd0);
        chk({tag, "_flush"}, {31'b0, flush_o}, 32'd0);
        chk({tag, "_misal"}, {31'b0, misal_o}, 32'd0);
        chk({tag, "_bad"}, bad_o, 32'd0);
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rst = 1;
        #22;
        chk_reset_values("reset");

        // Release reset; BOOT cycle then sequential fetch from RESET_PC
        @(posedge clk); #1; rst = 0;
        #1;
        chk_reset_values("boot");
        cycle(); chk("first_fetch", pc_o, 32'h0);
        cycle(); chk("seq_4", pc_o, 32'h4);
        cycle(); chk("seq_8", pc_o, 32'h8);

        // Taken branch backwards, two flush cycles
        ex_valid = 1; opcode = T_BRANCH; br_taken = 1; ex_pc = 32'h100; imm = 32'hFFFF_FFF0;
        cycle(); chk("br_target", pc_o, 32'hF0); chk("br_flush1", {31'b0, flush_o}, 32'd1);
        idle_inputs();
        cycle(); chk("br_f4", pc_o, 32'hF4); chk("br_flush2", {31'b0, flush_o}, 32'd1);
        cycle(); chk("br_f8", pc_o, 32'hF8); chk("br_flush_end", {31'b0, flush_o}, 32'd0);

        // Not-taken branch: normal sequencing
        ex_valid = 1; opcode = T_BRANCH; br_taken = 0; ex_pc = 32'h100; imm = 32'h40;
        cycle(); chk("br_not_taken", pc_o, 32'hFC);
        idle_inputs();

        // JALR aligned after LSB clear, then misaligned
        ex_valid = 1; opcode = T_JALR; rs1 = 32'h2001; imm = 32'h4;
        cycle(); chk("jalr_target", pc_o, 32'h2004);
        idle_inputs(); cycle(); cycle();
        ex_valid = 1; opcode = T_JALR; rs1 = 32'h2002; imm = 32'h4;
        cycle(); chk("jalr_misal", {31'b0, misal_o}, 32'd1); chk("jalr_bad", bad_o, 32'h2006);
        chk("jalr_misal_pc", pc_o, 32'h2010); chk("jalr_no_flush", {31'b0, flush_o}, 32'd0);
        idle_inputs();
        cycle(); chk("misal_pulse_end", {31'b0, misal_o}, 32'd0);

        // Redirect beats stall; stall alone holds PC
        stall = 1; ex_valid = 1; opcode = T_BRANCH; br_taken = 1; ex_pc = 32'h300; imm = 32'h100;
        cycle(); chk("stall_redirect", pc_o, 32'h400);
        ex_valid = 0; br_taken = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(); chk("stall_hold", pc_o, 32'h400);
        end
        stall = 0;

        // Trap wins over branch; trap during FLUSH restarts the count
        trap = 1; trap_vec = 32'h83; ex_valid = 1; opcode = T_BRANCH; br_taken = 1;
        ex_pc = 32'h1000; imm = 32'h8;
        cycle(); chk("trap_prio", pc_o, 32'h80);
        idle_inputs();
        cycle();
        trap = 1; trap_vec = 32'h200;
        cycle(); chk("trap_in_flush", pc_o, 32'h200);
        idle_inputs();
        cycle(); chk("trap_restart_f1", {31'b0, flush_o}, 32'd1);
        cycle(); chk("trap_restart_end", {31'b0, flush_o}, 32'd0);

        // MRET and JAL ignored during FLUSH
        mret = 1; epc = 32'h5556;
        cycle(); chk("mret_target", pc_o, 32'h5554);
        mret = 0; ex_valid = 1; opcode = T_JAL; ex_pc = 32'h0; imm = 32'h700;
        cycle(); chk("jal_ignored_in_flush", pc_o, 32'h5558);
        idle_inputs(); cycle();

        // Asynchronous reset mid-FLUSH
        ex_valid = 1; opcode = T_JAL; ex_pc = 32'h40; imm = 32'h40;
        cycle(); idle_inputs();
        #2 rst = 1;
        #1;
        chk_reset_values("async_rst");
        model_reset();
        @(posedge clk); #1; rst = 0;
        cycle(); cycle();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            int r;
            r        = int'($urandom_range(0, 99));
            trap     = (r < 4);
            mret     = (r >= 4 && r < 8);
            trap_vec = $urandom;
            epc      = $urandom;
            stall    = ($urandom_range(0, 3) == 0);
            ex_valid = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0: opcode = T_BRANCH;
                1: opcode = T_JAL;
                2: opcode = T_JALR;
                default: opcode = T_ALU;
            endcase
            br_taken = $urandom_range(0, 1) != 0;
            ex_pc    = $urandom & 32'hFFFF_FFFC;
            imm      = ($urandom_range(0, 5) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            rs1      = $urandom;
            if ($urandom_range(0, 49) == 0) begin
                ex_pc = 32'hFFFF_FFFC; imm = 32'h0; opcode = T_JAL; trap = 0; mret = 0;
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
